// File: rtl/micro_seq_v.sv
// Micro-instruction sequencer: queues micro-op codes in a small FIFO, decodes each
// into arithmetic / logic / branch class and drives that class strobe for a fixed cycle count.
module micro_seq_v #(
    parameter int CODE_W     = 4,
    parameter int DEPTH      = 4,
    parameter int A_CYC      = 2,
    parameter int L_CYC      = 1,
    parameter int B_CYC      = 3,
    parameter bit FLUSH_ON_B = 1'b1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_en,
    input  logic                       i_valid,
    input  logic [CODE_W-1:0]          i_code,
    output logic                       o_ready,
    output logic                       o_A,
    output logic                       o_L,
    output logic                       o_B,
    output logic                       o_err,
    output logic                       o_flush,
    output logic                       o_busy,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [3:0] A_LD = 4'(A_CYC - 1);
    localparam logic [3:0] L_LD = 4'(L_CYC - 1);
    localparam logic [3:0] B_LD = 4'(B_CYC - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        CLS_ILL = 2'd0,
        CLS_A   = 2'd1,
        CLS_L   = 2'd2,
        CLS_B   = 2'd3
    } cls_t;

    // Any bit above bit 3 set makes the code illegal regardless of the low nibble.
    function automatic cls_t decode(input logic [CODE_W-1:0] c);
        cls_t r;
        r = CLS_ILL;
        if ((c >> 4) == '0) begin
            unique case (c[3:0])
                4'hA, 4'hB, 4'hC:       r = CLS_A;
                4'h2, 4'h3, 4'h4, 4'hE: r = CLS_L;
                4'hF:                   r = CLS_B;
                default:                r = CLS_ILL;
            endcase
        end
        return r;
    endfunction

    // FIFO storage and bookkeeping
    logic [CODE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    // Sequencer state
    state_t     state, state_n;
    logic [3:0] exec_cnt, exec_cnt_n;
    logic       a_q, l_q, b_q;
    logic       a_n, l_n, b_n;
    logic       err_q, err_n;
    logic       flush_q, flush_n;

    logic push;
    logic pop;
    logic do_flush;
    cls_t head_cls;

    assign o_ready  = (count < CNT_W'(DEPTH)) && !i_rst;
    assign push     = i_valid && o_ready;
    assign head_cls = decode(mem[rd_ptr]);
    assign pop      = i_en && (count != '0) &&
                      ((state == IDLE) || (exec_cnt == 4'd0));
    assign do_flush = pop && (head_cls == CLS_B) && FLUSH_ON_B;

    always_comb begin
        state_n    = state;
        exec_cnt_n = exec_cnt;
        a_n        = a_q;
        l_n        = l_q;
        b_n        = b_q;
        err_n      = 1'b0;
        flush_n    = 1'b0;
        if (pop) begin
            a_n = 1'b0;
            l_n = 1'b0;
            b_n = 1'b0;
            unique case (head_cls)
                CLS_A: begin
                    state_n    = EXEC;
                    exec_cnt_n = A_LD;
                    a_n        = 1'b1;
                end
                CLS_L: begin
                    state_n    = EXEC;
                    exec_cnt_n = L_LD;
                    l_n        = 1'b1;
                end
                CLS_B: begin
                    state_n    = EXEC;
                    exec_cnt_n = B_LD;
                    b_n        = 1'b1;
                    flush_n    = FLUSH_ON_B;
                end
                default: begin
                    state_n    = IDLE;
                    exec_cnt_n = 4'd0;
                    err_n      = 1'b1;
                end
            endcase
        end else if (state == EXEC && i_en) begin
            if (exec_cnt != 4'd0) begin
                exec_cnt_n = exec_cnt - 4'd1;
            end else begin
                state_n = IDLE;
                a_n     = 1'b0;
                l_n     = 1'b0;
                b_n     = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            exec_cnt <= 4'd0;
            a_q      <= 1'b0;
            l_q      <= 1'b0;
            b_q      <= 1'b0;
            err_q    <= 1'b0;
            flush_q  <= 1'b0;
        end else begin
            state    <= state_n;
            exec_cnt <= exec_cnt_n;
            a_q      <= a_n;
            l_q      <= l_n;
            b_q      <= b_n;
            err_q    <= err_n;
            flush_q  <= flush_n;
        end
    end

    // A flush moves the read pointer onto the write pointer, so only a same-cycle push survives.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_flush) begin
                rd_ptr <= wr_ptr;
                count  <= push ? CNT_W'(1) : '0;
            end else begin
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                unique case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_code;
        end
    end

    // Strobes are gated by the enable so a stall blanks them without losing the op.
    assign o_A     = a_q && i_en;
    assign o_L     = l_q && i_en;
    assign o_B     = b_q && i_en;
    assign o_err   = err_q;
    assign o_flush = flush_q;
    assign o_busy  = (state == EXEC);
    assign o_count = count;

endmodule

// File: tb/tb_micro_seq_v.sv
// Directed bench for micro_seq_v (CODE_W=5, other parameters at their defaults).
module tb_micro_seq_v;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       valid;
    logic [4:0] code;
    logic       ready;
    logic       a, l, b;
    logic       err;
    logic       flush;
    logic       busy;
    logic [2:0] count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    micro_seq_v #(
        .CODE_W    (5),
        .DEPTH     (4),
        .A_CYC     (2),
        .L_CYC     (1),
        .B_CYC     (3),
        .FLUSH_ON_B(1'b1)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_en   (en),
        .i_valid(valid),
        .i_code (code),
        .o_ready(ready),
        .o_A    (a),
        .o_L    (l),
        .o_B    (b),
        .o_err  (err),
        .o_flush(flush),
        .o_busy (busy),
        .o_count(count)
    );

    // Output bundle: A=0x20 L=0x10 B=0x08 err=0x04 flush=0x02 busy=0x01
    function automatic logic [7:0] outs();
        return {2'b00, a, l, b, err, flush, busy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst   = 1'b1;
        en    = 1'b1;
        valid = 1'b0;
        code  = 5'h00;
        #2;
        chk("rst_outs", outs(), 8'h00);
        chk("rst_count", {5'b0, count}, 8'd0);
        chk("rst_ready", {7'b0, ready}, 8'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {7'b0, ready}, 8'd1);

        // 1: single A op
        valid = 1'b1; code = 5'h0A;
        tick();
        valid = 1'b0;
        chk("t1_queued_outs", outs(), 8'h00);
        chk("t1_queued_count", {5'b0, count}, 8'd1);
        tick();
        chk("t1_a_c1", outs(), 8'h21);
        chk("t1_count_c1", {5'b0, count}, 8'd0);
        tick();
        chk("t1_a_c2", outs(), 8'h21);
        tick();
        chk("t1_idle", outs(), 8'h00);

        // 2: back-to-back L, A, L
        valid = 1'b1; code = 5'h03;
        tick();
        chk("t2_q1_count", {5'b0, count}, 8'd1);
        chk("t2_q1_outs", outs(), 8'h00);
        code = 5'h0C;
        tick();
        chk("t2_l1", outs(), 8'h11);
        chk("t2_l1_count", {5'b0, count}, 8'd1);
        code = 5'h0E;
        tick();
        valid = 1'b0;
        chk("t2_a1", outs(), 8'h21);
        chk("t2_a1_count", {5'b0, count}, 8'd1);
        tick();
        chk("t2_a2", outs(), 8'h21);
        tick();
        chk("t2_l2", outs(), 8'h11);
        chk("t2_end_count", {5'b0, count}, 8'd0);
        tick();
        chk("t2_idle", outs(), 8'h00);

        // 3: fill while stalled, fifth offer refused, then drain in order
        en = 1'b0; valid = 1'b1;
        code = 5'h02; tick();
        chk("t3_c1", {5'b0, count}, 8'd1);
        code = 5'h0A; tick();
        code = 5'h04; tick();
        chk("t3_c3_ready", {7'b0, ready}, 8'd1);
        code = 5'h0E; tick();
        chk("t3_full_count", {5'b0, count}, 8'd4);
        chk("t3_full_ready", {7'b0, ready}, 8'd0);
        code = 5'h03; tick();
        valid = 1'b0;
        chk("t3_reject_count", {5'b0, count}, 8'd4);
        chk("t3_stall_outs", outs(), 8'h00);
        en = 1'b1;
        tick();
        chk("t3_d_l", outs(), 8'h11);
        chk("t3_d_count", {5'b0, count}, 8'd3);
        chk("t3_d_ready", {7'b0, ready}, 8'd1);
        tick();
        chk("t3_d_a1", outs(), 8'h21);
        tick();
        chk("t3_d_a2", outs(), 8'h21);
        tick();
        chk("t3_d_l2", outs(), 8'h11);
        tick();
        chk("t3_d_l3", outs(), 8'h11);
        chk("t3_d_count_end", {5'b0, count}, 8'd0);
        tick();
        chk("t3_idle", outs(), 8'h00);

        // 4: branch flush with a same-cycle push surviving
        en = 1'b0; valid = 1'b1;
        code = 5'h0F; tick();
        code = 5'h0A; tick();
        code = 5'h0B; tick();
        chk("t4_q_count", {5'b0, count}, 8'd3);
        en = 1'b1; code = 5'h02;
        tick();
        valid = 1'b0;
        chk("t4_flush", outs(), 8'h0B);
        chk("t4_flush_count", {5'b0, count}, 8'd1);
        tick();
        chk("t4_b2", outs(), 8'h09);
        tick();
        chk("t4_b3", outs(), 8'h09);
        tick();
        chk("t4_l", outs(), 8'h11);
        chk("t4_l_count", {5'b0, count}, 8'd0);
        tick();
        chk("t4_idle", outs(), 8'h00);

        // 5: illegal codes
        valid = 1'b1; code = 5'h07;
        tick();
        valid = 1'b0;
        chk("t5_q1", outs(), 8'h00);
        tick();
        chk("t5_err1", outs(), 8'h04);
        chk("t5_err1_count", {5'b0, count}, 8'd0);
        valid = 1'b1; code = 5'h1F;
        tick();
        valid = 1'b0;
        chk("t5_err_clear", outs(), 8'h00);
        tick();
        chk("t5_err2", outs(), 8'h04);
        tick();
        chk("t5_idle", outs(), 8'h00);

        // 6: stall in the second A cycle, then reset mid-op
        valid = 1'b1; code = 5'h0A;
        tick();
        valid = 1'b0;
        tick();
        chk("t6_a1", outs(), 8'h21);
        tick();
        chk("t6_a2", outs(), 8'h21);
        en = 1'b0;
        #1;
        chk("t6_stall0", outs(), 8'h01);
        tick();
        chk("t6_stall1", outs(), 8'h01);
        tick();
        chk("t6_stall2", outs(), 8'h01);
        tick();
        en = 1'b1;
        #1;
        chk("t6_resume", outs(), 8'h21);
        tick();
        chk("t6_done", outs(), 8'h00);

        valid = 1'b1; code = 5'h0C;
        tick();
        code = 5'h02;
        tick();
        valid = 1'b0;
        chk("t6_rop", outs(), 8'h21);
        chk("t6_rop_count", {5'b0, count}, 8'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_outs", outs(), 8'h00);
        chk("t6_rst_count", {5'b0, count}, 8'd0);
        chk("t6_rst_ready", {7'b0, ready}, 8'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_after_rst", outs(), 8'h00);
        chk("t6_after_count", {5'b0, count}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
